// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers:
// bundle widths per boundary, the bubble control word and bundle field offsets.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    BOUND_FD,
    BOUND_DE,
    BOUND_EM,
    BOUND_MW
  } boundary_t;

  localparam int CTRL_W_FD = 1;
  localparam int DATA_W_FD = 64;
  localparam int CTRL_W_DE = 11;
  localparam int DATA_W_DE = 216;
  localparam int CTRL_W_EM = 5;
  localparam int DATA_W_EM = 106;
  localparam int CTRL_W_MW = 2;
  localparam int DATA_W_MW = 69;

  // A bubble must never write a register or memory, so every control bit is zero.
  localparam int CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] BUBBLE_CTRL = '0;

  localparam int DE_CTRL_REGWRITE = 0;
  localparam int DE_CTRL_REGDST   = 1;
  localparam int DE_CTRL_WRITESEL = 2;
  localparam int DE_CTRL_ALUSRC   = 4;
  localparam int DE_CTRL_ALUCTRL  = 5;
  localparam int DE_CTRL_MEMWRITE = 8;
  localparam int DE_CTRL_MEMTOREG = 9;
  localparam int DE_CTRL_BRANCH   = 10;

  localparam int DE_DATA_RD1     = 0;
  localparam int DE_DATA_RD2     = 32;
  localparam int DE_DATA_RS      = 64;
  localparam int DE_DATA_RT      = 69;
  localparam int DE_DATA_RD      = 74;
  localparam int DE_DATA_SIGNIMM = 79;
  localparam int DE_DATA_PC      = 111;
  localparam int DE_DATA_INSTR   = 143;
  localparam int DE_DATA_PCPLUS4 = 175;

  function automatic int ctrlWidth(input boundary_t b);
    case (b)
      BOUND_FD: return CTRL_W_FD;
      BOUND_DE: return CTRL_W_DE;
      BOUND_EM: return CTRL_W_EM;
      default:  return CTRL_W_MW;
    endcase
  endfunction

  function automatic int dataWidth(input boundary_t b);
    case (b)
      BOUND_FD: return DATA_W_FD;
      BOUND_DE: return DATA_W_DE;
      BOUND_EM: return DATA_W_EM;
      default:  return DATA_W_MW;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus control and data bundles.
// Kill drops the entry to a bubble (data held); load captures a new entry.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DE,
  parameter int DATA_W = DATA_W_DE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              kill_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE_CTRL[CTRL_W-1:0];
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE_CTRL[CTRL_W-1:0];
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional skid entry that makes in_ready a pure register output.
module pipe_stage_hs
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DE,
  parameter int DATA_W = DATA_W_DE,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept, emit, mainFree;
  logic              mainLoad, mainKill;
  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl, mainCtrlIn;
  logic [DATA_W-1:0] skidData, mainDataIn;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign mainFree = ~out_valid | out_ready;

  generate
    if (SKID != 0) begin : gSkid
      logic skidLoad, skidKill;

      // A held skid entry always has priority for the main slot to keep FIFO order.
      assign in_ready = ~skidValid;
      assign mainLoad = ~flush & mainFree & (skidValid | accept);
      assign skidLoad = ~flush & accept & ~mainFree;
      assign skidKill = flush | (skidValid & mainFree);

      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skidLoad),
        .kill_i  (skidKill),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skidValid),
        .ctrl_o  (skidCtrl),
        .data_o  (skidData)
      );
    end else begin : gNoSkid
      assign in_ready  = mainFree;
      assign mainLoad  = ~flush & accept;
      assign skidValid = 1'b0;
      assign skidCtrl  = '0;
      assign skidData  = '0;
    end
  endgenerate

  assign mainKill   = flush | (emit & ~mainLoad);
  assign mainCtrlIn = skidValid ? skidCtrl : in_ctrl;
  assign mainDataIn = skidValid ? skidData : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (mainLoad),
    .kill_i  (mainKill),
    .ctrl_i  (mainCtrlIn),
    .data_i  (mainDataIn),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  // Saturating backpressure counter; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: a skid instance with directed vectors,
// a single-entry instance under random traffic and a 3-bit counter instance.
module tb_pipe_stage_hs;
  import cpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic                 aInValid = 0, aInReady, aOutValid, aOutReady = 0, aFlush = 0;
  logic [CTRL_W_DE-1:0] aInCtrl = '0, aOutCtrl;
  logic [DATA_W_DE-1:0] aInData = '0, aOutData;
  logic [15:0]          aStall;

  logic                 bInValid = 0, bInReady, bOutValid, bOutReady = 0, bFlush = 0;
  logic [CTRL_W_DE-1:0] bInCtrl = '0, bOutCtrl;
  logic [DATA_W_DE-1:0] bInData = '0, bOutData;
  logic [15:0]          bStall;

  logic                 cInValid = 0, cInReady, cOutValid, cOutReady = 0;
  logic [CTRL_W_DE-1:0] cInCtrl = '0, cOutCtrl;
  logic [DATA_W_DE-1:0] cInData = '0, cOutData;
  logic [2:0]           cStall;

  pipe_stage_hs #(.SKID(1)) dutA (
    .clk(clk), .reset(reset), .flush(aFlush),
    .in_valid(aInValid), .in_ready(aInReady), .in_ctrl(aInCtrl), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_ctrl(aOutCtrl), .out_data(aOutData),
    .stall_cnt(aStall)
  );

  pipe_stage_hs #(.SKID(0)) dutB (
    .clk(clk), .reset(reset), .flush(bFlush),
    .in_valid(bInValid), .in_ready(bInReady), .in_ctrl(bInCtrl), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_ctrl(bOutCtrl), .out_data(bOutData),
    .stall_cnt(bStall)
  );

  pipe_stage_hs #(.SKID(1), .CNT_W(3)) dutC (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(cInValid), .in_ready(cInReady), .in_ctrl(cInCtrl), .in_data(cInData),
    .out_valid(cOutValid), .out_ready(cOutReady), .out_ctrl(cOutCtrl), .out_data(cOutData),
    .stall_cnt(cStall)
  );

  function automatic logic [DATA_W_DE-1:0] mkData(input logic [CTRL_W_DE-1:0] c);
    return {c, {25{c[7:0]}}, c[4:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CTRL_W_DE-1:0] c,
                               input logic r, input logic f);
    aInValid  = v;
    aInCtrl   = c;
    aInData   = mkData(c);
    aOutReady = r;
    aFlush    = f;
    @(posedge clk);
    #1;
  endtask

  logic [CTRL_W_DE-1:0] qA[$];
  logic [CTRL_W_DE-1:0] qB[$];
  logic [15:0]          stallA = 0, stallB = 0;
  logic                 expReadyA, expReadyB;
  logic [CTRL_W_DE-1:0] expA, expB;

  // Monitor for the skid instance: a 2-deep FIFO model.
  always @(negedge clk) begin
    if (!reset) begin
      qA.delete();
      stallA = 0;
    end else begin
      expReadyA = (qA.size() < 2);
      checkOutput("A in_ready", 256'(aInReady), 256'(expReadyA));
      checkOutput("A out_valid", 256'(aOutValid), 256'(qA.size() > 0));
      checkOutput("A stall_cnt", 256'(aStall), 256'(stallA));
      if (qA.size() > 0 && !aOutReady && stallA != 16'hFFFF) stallA = stallA + 16'd1;
      if (!aOutValid) begin
        checkOutput("A bubble ctrl", 256'(aOutCtrl), 256'(0));
      end else if (aOutReady && qA.size() > 0) begin
        expA = qA.pop_front();
        checkOutput("A out_ctrl", 256'(aOutCtrl), 256'(expA));
        checkOutput("A out_data", 256'(aOutData), 256'(mkData(expA)));
      end
      if (aFlush) qA.delete();
      else if (aInValid && expReadyA) qA.push_back(aInCtrl);
    end
  end

  // Monitor for the single-entry instance.
  always @(negedge clk) begin
    if (!reset) begin
      qB.delete();
      stallB = 0;
    end else begin
      expReadyB = bOutReady || (qB.size() == 0);
      checkOutput("B in_ready", 256'(bInReady), 256'(expReadyB));
      checkOutput("B out_valid", 256'(bOutValid), 256'(qB.size() > 0));
      checkOutput("B stall_cnt", 256'(bStall), 256'(stallB));
      if (qB.size() > 0 && !bOutReady && stallB != 16'hFFFF) stallB = stallB + 16'd1;
      if (!bOutValid) begin
        checkOutput("B bubble ctrl", 256'(bOutCtrl), 256'(0));
      end else if (bOutReady && qB.size() > 0) begin
        expB = qB.pop_front();
        checkOutput("B out_ctrl", 256'(bOutCtrl), 256'(expB));
        checkOutput("B out_data", 256'(bOutData), 256'(mkData(expB)));
      end
      if (bFlush) qB.delete();
      else if (bInValid && expReadyB) qB.push_back(bInCtrl);
    end
  end

  initial begin
    // Reset held with an upstream entry offered.
    aInValid = 1;
    aInCtrl  = 11'h5;
    aInData  = mkData(11'h5);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 256'(aOutValid), 256'(0));
    checkOutput("reset out_ctrl", 256'(aOutCtrl), 256'(0));
    checkOutput("reset out_data", 256'(aOutData), 256'(0));
    checkOutput("reset stall_cnt", 256'(aStall), 256'(0));
    aInValid = 0;
    #2;
    reset = 1;
    #1;
    checkOutput("release in_ready", 256'(aInReady), 256'(1));
    @(posedge clk);
    #1;

    // Back-to-back stream, one-cycle latency.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 11'(i), 1'b1, 1'b0);
      checkOutput("stream latency", 256'(aOutCtrl), 256'(i));
    end
    repeat (2) applyStimulus(1'b0, 11'h0, 1'b1, 1'b0);

    // Backpressure fills main then skid; third entry must wait.
    applyStimulus(1'b1, 11'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'h12, 1'b0, 1'b0);
    checkOutput("full in_ready", 256'(aInReady), 256'(0));
    checkOutput("full head ctrl", 256'(aOutCtrl), 256'(11'h11));
    repeat (2) applyStimulus(1'b1, 11'h13, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 11'h13, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 11'h0, 1'b1, 1'b0);
    checkOutput("skid drained", 256'(qA.size()), 256'(0));

    // Flush with both entries held and a new entry offered.
    applyStimulus(1'b1, 11'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'h23, 1'b0, 1'b1);
    checkOutput("flush out_valid", 256'(aOutValid), 256'(0));
    checkOutput("flush out_ctrl", 256'(aOutCtrl), 256'(0));
    checkOutput("flush in_ready", 256'(aInReady), 256'(1));
    checkOutput("flush data held", 256'(aOutData), 256'(mkData(11'h21)));
    repeat (3) applyStimulus(1'b0, 11'h0, 1'b1, 1'b0);

    // Saturating counter on the 3-bit instance.
    cInValid  = 1;
    cInCtrl   = 11'h3;
    cInData   = mkData(11'h3);
    cOutReady = 0;
    @(posedge clk);
    #1;
    cInValid = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("C stall after 3", 256'(cStall), 256'(3));
    repeat (7) @(posedge clk);
    #1;
    checkOutput("C stall saturated", 256'(cStall), 256'(7));
    checkOutput("C entry held", 256'(cOutCtrl), 256'(11'h3));

    // Asynchronous reset with entries held.
    applyStimulus(1'b1, 11'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'h32, 1'b0, 1'b0);
    applyStimulus(1'b0, 11'h0, 1'b0, 1'b0);
    reset = 0;
    #1;
    checkOutput("async out_valid", 256'(aOutValid), 256'(0));
    checkOutput("async out_ctrl", 256'(aOutCtrl), 256'(0));
    checkOutput("async stall_cnt", 256'(aStall), 256'(0));
    checkOutput("async in_ready", 256'(aInReady), 256'(1));
    checkOutput("async C stall", 256'(cStall), 256'(0));
    @(posedge clk);
    #2;
    reset = 1;
    @(posedge clk);
    #1;

    // Random traffic on the single-entry instance.
    for (int n = 0; n < 10000; n++) begin
      bInValid  = 1'($urandom_range(0, 1));
      bOutReady = 1'($urandom_range(0, 1));
      bFlush    = ($urandom_range(0, 63) == 0);
      bInCtrl   = 11'($urandom);
      bInData   = mkData(bInCtrl);
      @(posedge clk);
      #1;
    end
    bInValid  = 0;
    bOutReady = 1;
    bFlush    = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("B drained", 256'(qB.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
